// File: rtl/dispatch_credit_ctrl.sv
// rtl/dispatch_credit_ctrl.sv - credit-gated issue control for ROB/RS/LSB with misbranch drain window.
// Optional DISPATCH_CREDIT_CHECK_EN builds the sticky credit_err checker.
module dispatch_credit_ctrl #(
  parameter int ROB_DEPTH    = 16,
  parameter int RS_DEPTH     = 16,
  parameter int LSB_DEPTH    = 16,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rdy,
  input  logic                           if_valid,
  input  logic                           if_is_mem,
  input  logic                           if_is_nop,
  output logic                           issue_ok,
  input  logic                           rob_release,
  input  logic                           rs_release,
  input  logic                           lsb_release,
  input  logic                           misbranch_flag,
  input  logic [$clog2(LSB_DEPTH):0]     lsb_keep,
  output logic [$clog2(ROB_DEPTH):0]     rob_free,
  output logic [$clog2(RS_DEPTH):0]      rs_free,
  output logic [$clog2(LSB_DEPTH):0]     lsb_free,
  output logic                           flushing,
  output logic                           credit_err
);

  localparam int RW  = $clog2(ROB_DEPTH) + 1;
  localparam int SW  = $clog2(RS_DEPTH) + 1;
  localparam int LW  = $clog2(LSB_DEPTH) + 1;
  localparam int FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [RW-1:0]  ROB_MAX    = RW'(ROB_DEPTH);
  localparam logic [SW-1:0]  RS_MAX     = SW'(RS_DEPTH);
  localparam logic [LW-1:0]  LSB_MAX    = LW'(LSB_DEPTH);
  localparam logic [FCW-1:0] FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t          state_q, state_d;
  logic [FCW-1:0]  fcnt_q, fcnt_d;
  logic [RW-1:0]   rob_free_q, rob_free_d;
  logic [SW-1:0]   rs_free_q, rs_free_d;
  logic [LW-1:0]   lsb_free_q, lsb_free_d;
  logic [RW:0]     rob_sum;
  logic [SW:0]     rs_sum;
  logic [LW:0]     lsb_sum;
  logic            fire;
  logic            credit_ok;

  always_comb begin
    credit_ok = (rob_free_q != '0) && (if_is_mem ? (lsb_free_q != '0) : (rs_free_q != '0));
    issue_ok  = rdy && (state_q == RUN) && !misbranch_flag && if_valid && !if_is_nop && credit_ok;
    fire      = issue_ok;
  end

  // Sums carry one extra bit so a release at DEPTH can be clamped back; fire never hits 0.
  always_comb begin
    rob_sum = {1'b0, rob_free_q} + (RW+1)'(rob_release) - (RW+1)'(fire);
    rs_sum  = {1'b0, rs_free_q}  + (SW+1)'(rs_release)  - (SW+1)'(fire && !if_is_mem);
    lsb_sum = {1'b0, lsb_free_q} + (LW+1)'(lsb_release) - (LW+1)'(fire && if_is_mem);

    rob_free_d = rob_free_q;
    rs_free_d  = rs_free_q;
    lsb_free_d = lsb_free_q;
    if (rdy) begin
      if (misbranch_flag) begin
        rob_free_d = ROB_MAX;
        rs_free_d  = RS_MAX;
        lsb_free_d = (lsb_keep > LSB_MAX) ? '0 : LSB_MAX - lsb_keep;
      end else begin
        rob_free_d = (rob_sum > {1'b0, ROB_MAX}) ? ROB_MAX : rob_sum[RW-1:0];
        rs_free_d  = (rs_sum  > {1'b0, RS_MAX})  ? RS_MAX  : rs_sum[SW-1:0];
        lsb_free_d = (lsb_sum > {1'b0, LSB_MAX}) ? LSB_MAX : lsb_sum[LW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    if (rdy) begin
      case (state_q)
        RUN: begin
          if (misbranch_flag) begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_LOAD;
          end
        end
        FLUSH: begin
          if (misbranch_flag) begin
            fcnt_d = FLUSH_LOAD;
          end else if (fcnt_q == '0) begin
            state_d = RUN;
          end else begin
            fcnt_d = fcnt_q - 1'b1;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      fcnt_q     <= '0;
      rob_free_q <= ROB_MAX;
      rs_free_q  <= RS_MAX;
      lsb_free_q <= LSB_MAX;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      rob_free_q <= rob_free_d;
      rs_free_q  <= rs_free_d;
      lsb_free_q <= lsb_free_d;
    end
  end

  assign rob_free = rob_free_q;
  assign rs_free  = rs_free_q;
  assign lsb_free = lsb_free_q;
  assign flushing = (state_q == FLUSH);

`ifdef DISPATCH_CREDIT_CHECK_EN
  logic credit_err_q, credit_err_d;

  always_comb begin
    credit_err_d = credit_err_q;
    if (rdy) begin
      if ((rob_release && rob_free_q == ROB_MAX) ||
          (rs_release  && rs_free_q  == RS_MAX)  ||
          (lsb_release && lsb_free_q == LSB_MAX) ||
          (misbranch_flag && lsb_keep > LSB_MAX)) begin
        credit_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) credit_err_q <= 1'b0;
    else     credit_err_q <= credit_err_d;
  end

  assign credit_err = credit_err_q;
`else
  assign credit_err = 1'b0;
`endif

endmodule

// File: tb/tb_dispatch_credit_ctrl.sv
// tb/tb_dispatch_credit_ctrl.sv - scoreboard bench for dispatch_credit_ctrl at default parameters.
module tb_dispatch_credit_ctrl;

  logic       clk = 1'b0;
  logic       rst, rdy, if_valid, if_is_mem, if_is_nop;
  logic       rob_release, rs_release, lsb_release, misbranch_flag;
  logic [4:0] lsb_keep;
  logic       issue_ok, flushing, credit_err;
  logic [4:0] rob_free, rs_free, lsb_free;

  int         total  = 0;
  int         passed = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic [31:0] obs, e;
  string       t;

`ifdef DISPATCH_CREDIT_CHECK_EN
  localparam logic [31:0] ERR_EXP = 32'd1;
`else
  localparam logic [31:0] ERR_EXP = 32'd0;
`endif

  dispatch_credit_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .if_valid(if_valid), .if_is_mem(if_is_mem), .if_is_nop(if_is_nop),
    .issue_ok(issue_ok),
    .rob_release(rob_release), .rs_release(rs_release), .lsb_release(lsb_release),
    .misbranch_flag(misbranch_flag), .lsb_keep(lsb_keep),
    .rob_free(rob_free), .rs_free(rs_free), .lsb_free(lsb_free),
    .flushing(flushing), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_valid = 0; if_is_mem = 0; if_is_nop = 0;
    rob_release = 0; rs_release = 0; lsb_release = 0;
    misbranch_flag = 0; lsb_keep = '0; rdy = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick(); rst = 0;
    exp_q.push_back(16); tag_q.push_back("reset_rob_free");
    exp_q.push_back(16); tag_q.push_back("reset_rs_free");
    exp_q.push_back(16); tag_q.push_back("reset_lsb_free");
    exp_q.push_back(0);  tag_q.push_back("reset_flushing");
    exp_q.push_back(0);  tag_q.push_back("reset_credit_err");
    exp_q.push_back(0);  tag_q.push_back("reset_issue_ok");
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: obs = {27'b0, rob_free};
        1: obs = {27'b0, rs_free};
        2: obs = {27'b0, lsb_free};
        3: obs = {31'b0, flushing};
        4: obs = {31'b0, credit_err};
        default: obs = {31'b0, issue_ok};
      endcase
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e);
      else passed++;
    end
  endtask

  task automatic test_rs_drain();
    int m_rob = 16;
    int m_rs  = 16;
    int grants = 0;
    if_valid = 1; if_is_mem = 0;
    for (int i = 0; i < 20; i++) begin
      #3;
      exp_q.push_back((m_rob > 0 && m_rs > 0) ? 1 : 0); tag_q.push_back("drain_issue_ok");
      obs = {31'b0, issue_ok};
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs !== e) $display("FAIL %s cyc%0d: got %0d expected %0d", t, i, obs, e);
      else passed++;
      if (e == 1) begin m_rob--; m_rs--; end
      if (issue_ok) grants++;
      tick();
    end
    exp_q.push_back(16); tag_q.push_back("drain_grants");
    exp_q.push_back(0);  tag_q.push_back("drain_rob_free");
    exp_q.push_back(0);  tag_q.push_back("drain_rs_free");
    for (int k = 0; k < 3; k++) begin
      obs = (k == 0) ? grants : (k == 1) ? {27'b0, rob_free} : {27'b0, rs_free};
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e);
      else passed++;
    end
  endtask

  task automatic test_release_next_cycle();
    rob_release = 1; rs_release = 1;
    exp_q.push_back(0); tag_q.push_back("release_same_cycle_issue_ok");
    exp_q.push_back(1); tag_q.push_back("release_next_cycle_issue_ok");
    exp_q.push_back(0); tag_q.push_back("release_refire_rob_free");
    #3;
    obs = {31'b0, issue_ok};
    e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
    if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
    tick();
    rob_release = 0; rs_release = 0;
    #3;
    obs = {31'b0, issue_ok};
    e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
    if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
    if_valid = 1;
    tick();
    obs = {27'b0, rob_free};
    e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
    if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
  endtask

  task automatic test_mem_release();
    idle_inputs();
    rst = 1; tick(); rst = 0;
    if_valid = 1; if_is_mem = 1;
    for (int k = 1; k <= 4; k++) begin
      lsb_release = (k >= 2);
      exp_q.push_back(1); tag_q.push_back("mem_issue_ok");
      #3;
      obs = {31'b0, issue_ok};
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs !== e) $display("FAIL %s fire%0d: got %0d expected %0d", t, k, obs, e); else passed++;
      tick();
    end
    if_valid = 0; lsb_release = 0;
    exp_q.push_back(15); tag_q.push_back("mem_lsb_free");
    exp_q.push_back(12); tag_q.push_back("mem_rob_free");
    exp_q.push_back(16); tag_q.push_back("mem_rs_free");
    for (int k = 0; k < 3; k++) begin
      obs = (k == 0) ? {27'b0, lsb_free} : (k == 1) ? {27'b0, rob_free} : {27'b0, rs_free};
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
    end
  endtask

  task automatic test_flush();
    if_valid = 1; if_is_mem = 0; misbranch_flag = 1; lsb_keep = 5'd3; rob_release = 1;
    exp_q.push_back(0); tag_q.push_back("flush_flag_cycle_issue_ok");
    #3;
    obs = {31'b0, issue_ok};
    e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
    if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
    tick();
    misbranch_flag = 0; lsb_keep = '0; rob_release = 0;
    exp_q.push_back(16); tag_q.push_back("flush_rob_free");
    exp_q.push_back(16); tag_q.push_back("flush_rs_free");
    exp_q.push_back(13); tag_q.push_back("flush_lsb_free");
    for (int k = 0; k < 3; k++) begin
      obs = (k == 0) ? {27'b0, rob_free} : (k == 1) ? {27'b0, rs_free} : {27'b0, lsb_free};
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
    end
    // Cycles N+1..N+3 after the flag: flushing 1,1,0 and issue_ok 0,0,1.
    for (int c = 1; c <= 3; c++) begin
      exp_q.push_back((c < 3) ? 1 : 0); tag_q.push_back("flush_flushing");
      exp_q.push_back((c < 3) ? 0 : 1); tag_q.push_back("flush_issue_ok");
      #3;
      obs = {31'b0, flushing};
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs !== e) $display("FAIL %s N+%0d: got %0d expected %0d", t, c, obs, e); else passed++;
      obs = {31'b0, issue_ok};
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs !== e) $display("FAIL %s N+%0d: got %0d expected %0d", t, c, obs, e); else passed++;
      if (c == 3) if_valid = 0;
      tick();
    end
    misbranch_flag = 1; lsb_keep = 5'd20;
    tick();
    misbranch_flag = 0; lsb_keep = '0;
    exp_q.push_back(0);       tag_q.push_back("flush_keep_clamp_lsb_free");
    exp_q.push_back(ERR_EXP); tag_q.push_back("flush_keep_clamp_credit_err");
    obs = {27'b0, lsb_free};
    e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
    if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
    obs = {31'b0, credit_err};
    e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
    if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
    tick(); tick();
  endtask

  task automatic test_rdy_low();
    idle_inputs();
    rst = 1; tick(); rst = 0;
    if_valid = 1; if_is_mem = 0;
    tick(); tick();
    rdy = 0; rob_release = 1; rs_release = 1; lsb_release = 1;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(0); tag_q.push_back("rdy_low_issue_ok");
      #3;
      obs = {31'b0, issue_ok};
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs !== e) $display("FAIL %s cyc%0d: got %0d expected %0d", t, i, obs, e); else passed++;
      tick();
    end
    exp_q.push_back(14); tag_q.push_back("rdy_low_rob_free");
    exp_q.push_back(14); tag_q.push_back("rdy_low_rs_free");
    exp_q.push_back(16); tag_q.push_back("rdy_low_lsb_free");
    exp_q.push_back(0);  tag_q.push_back("rdy_low_credit_err");
    for (int k = 0; k < 4; k++) begin
      case (k)
        0: obs = {27'b0, rob_free};
        1: obs = {27'b0, rs_free};
        2: obs = {27'b0, lsb_free};
        default: obs = {31'b0, credit_err};
      endcase
      e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
      if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    idle_inputs();
    rst = 1; tick(); rst = 0;
    rs_release = 1;
    tick();
    rs_release = 0;
    exp_q.push_back(16);      tag_q.push_back("sat_rs_free");
    exp_q.push_back(ERR_EXP); tag_q.push_back("sat_credit_err");
    exp_q.push_back(ERR_EXP); tag_q.push_back("sat_credit_err_held");
    exp_q.push_back(0);       tag_q.push_back("sat_credit_err_after_rst");
    obs = {27'b0, rs_free};
    e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
    if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
    obs = {31'b0, credit_err};
    e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
    if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
    tick(); tick(); tick();
    obs = {31'b0, credit_err};
    e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
    if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
    rst = 1; tick(); rst = 0;
    obs = {31'b0, credit_err};
    e = exp_q.pop_front(); t = tag_q.pop_front(); total++;
    if (obs !== e) $display("FAIL %s: got %0d expected %0d", t, obs, e); else passed++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1;
    idle_inputs();
    test_reset();
    test_rs_drain();
    test_release_next_cycle();
    test_mem_release();
    test_flush();
    test_rdy_low();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
